// File: rtl/bc_fir_decim_pkg.sv
// Shared types and arithmetic helpers for the decimating FIR.
// Holds the FSM encoding, the dec_sel codes and the round/saturate function.
package bc_fir_pkg;

    typedef enum logic [1:0] {IDLE, MAC, OUT} fsm_e;

    localparam logic [1:0] DEC_1 = 2'd0;
    localparam logic [1:0] DEC_2 = 2'd1;
    localparam logic [1:0] DEC_4 = 2'd2;
    localparam logic [1:0] DEC_8 = 2'd3;

    function automatic logic [3:0] dec_ratio(input logic [1:0] sel);
        return 4'd1 << sel;
    endfunction

    // Round half up, then clamp; 64-bit working width so no stage can wrap.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                     input int frac, input int width);
        logic signed [63:0] r, hi, lo;
        r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (r > hi) return hi;
        if (r < lo) return lo;
        return r;
    endfunction

endpackage

// File: rtl/bc_fir_decim_if.sv
// Sample-in / sample-out stream pair of the decimating FIR.
// master = the side feeding samples and consuming results, slave = the filter.
interface bc_fir_decim_if #(parameter int DATA_W = 13) ();
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid);
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid);
endinterface

// File: rtl/bc_fir_decim_mac.sv
// Registered signed multiply-accumulate with combinational round/saturate output.
module bc_fir_mac
    import bc_fir_pkg::*;
#(
    parameter int DATA_W    = 13,
    parameter int COEF_W    = 13,
    parameter int COEF_FRAC = 11,
    parameter int ACC_W     = 31
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] d,
    input  logic signed [COEF_W-1:0] c,
    output logic signed [DATA_W-1:0] res
);
    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [PROD_W-1:0] w_prod;

    assign w_prod = PROD_W'(d) * PROD_W'(c);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  r_acc <= '0;
        else if (clr)  r_acc <= '0;
        else if (en)   r_acc <= r_acc + ACC_W'(w_prod);
    end

    assign res = DATA_W'(sat_round(64'(r_acc), COEF_FRAC, DATA_W));
endmodule

// File: rtl/bc_fir_decim.sv
// Time-multiplexed FIR with runtime decimation: delay line, coefficient bank,
// decimation counter and IDLE/MAC/OUT sequencer around one shared MAC.
module bc_fir_decim
    import bc_fir_pkg::*;
#(
    parameter int DATA_W    = 13,
    parameter int COEF_W    = 13,
    parameter int COEF_FRAC = 11,
    parameter int TAPS      = 19
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      clr,
    input  logic [1:0]                dec_sel,
    bc_fir_decim_if.slave             bus,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    output logic                      busy
);
    localparam int ADDR_W = $clog2(TAPS);
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << COEF_FRAC);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);

    fsm_e                     r_state, w_nxt;
    logic signed [DATA_W-1:0] r_dl   [TAPS];
    logic signed [COEF_W-1:0] r_coef [TAPS];
    logic [2:0]               r_cnt;
    logic [1:0]               r_sel, w_sel;
    logic [ADDR_W-1:0]        r_idx;
    logic                     w_accept, w_trig;
    logic signed [DATA_W-1:0] w_res;

    // Ratio may only change on a frame boundary; the boundary accept itself uses the new value.
    assign w_sel    = (r_state == IDLE && r_cnt == 3'd0) ? dec_sel : r_sel;
    assign w_accept = bus.in_valid && bus.in_ready && !clr;
    assign w_trig   = w_accept && (r_cnt == 3'(dec_ratio(w_sel) - 4'd1));

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    if (w_trig) w_nxt = MAC;
            MAC:     if (r_idx == LAST) w_nxt = OUT;
            OUT:     if (bus.out_ready) w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
        if (clr) w_nxt = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel   <= DEC_1;
            r_idx   <= '0;
        end else begin
            r_state <= w_nxt;
            r_sel   <= w_sel;
            r_idx   <= (r_state == MAC && r_idx != LAST && !clr) ? r_idx + ADDR_W'(1) : '0;
            if (clr)           r_cnt <= '0;
            else if (w_accept) r_cnt <= w_trig ? 3'd0 : r_cnt + 3'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) r_dl[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < TAPS; k++) r_dl[k] <= '0;
        end else if (w_accept) begin
            r_dl[0] <= bus.in_data;
            for (int k = 1; k < TAPS; k++) r_dl[k] <= r_dl[k-1];
        end
    end

    // Bank only changes while IDLE so a running MAC pass never sees mixed coefficient sets.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) r_coef[k] <= (k == 0) ? COEF_ONE : '0;
        end else if (!clr && coef_we && r_state == IDLE && int'(coef_addr) < TAPS) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    bc_fir_mac #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .COEF_FRAC (COEF_FRAC),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clr || w_trig),
        .en      (r_state == MAC && !clr),
        .d       (r_dl[r_idx]),
        .c       (r_coef[r_idx]),
        .res     (w_res)
    );

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == OUT);
    assign bus.out_data  = (r_state == OUT) ? w_res : '0;
    assign busy          = (r_state != IDLE);
endmodule

// File: tb/tb_bc_fir_decim.sv
// Scoreboard bench for bc_fir_decim: directed samples push expected results,
// a negedge monitor pops and checks them on every output handshake.
module tb_bc_fir_decim;
    import bc_fir_pkg::*;

    typedef struct {
        int d;
        bit lat;
        int t;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              clr = 1'b0;
    logic [1:0]        dec_sel = DEC_1;
    logic              coef_we = 1'b0;
    logic [4:0]        coef_addr = '0;
    logic signed [12:0] coef_data = '0;
    logic              busy;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sbq[$];

    bc_fir_decim_if #(.DATA_W(13)) bus ();

    bc_fir_decim #(.DATA_W(13), .COEF_W(13), .COEF_FRAC(11), .TAPS(19)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clr       (clr),
        .dec_sel   (dec_sel),
        .bus       (bus),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Monitor: one pop per output handshake, optional first-valid latency check.
    initial begin
        bit   prev_v;
        int   t_rise;
        exp_t e;
        prev_v = 1'b0;
        t_rise = 0;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (bus.out_valid && !prev_v) t_rise = cyc;
                if (bus.out_valid && bus.out_ready) begin
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out got=%0d want=none", int'(bus.out_data));
                    end else begin
                        e = sbq.pop_front();
                        chk("out_data", int'(bus.out_data), e.d);
                        if (e.lat) chk("latency", t_rise - e.t, 20);
                    end
                end
                prev_v = bus.out_valid;
            end else begin
                prev_v = 1'b0;
            end
        end
    end

    task automatic send(input int x, input bit push, input int e, input bit lat);
        int n;
        n = 0;
        @(negedge clock);
        bus.in_data  = 13'(x);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL send_timeout in_ready=0 want=1");
        end else if (push) begin
            sbq.push_back('{d: e, lat: lat, t: cyc});
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wcoef(input int a, input int v);
        @(posedge clock);
        #1;
        coef_we   = 1'b1;
        coef_addr = 5'(a);
        coef_data = 13'(v);
        @(posedge clock);
        #1;
        coef_we   = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clock);
        #1 clr = 1'b1;
        @(posedge clock);
        #1 clr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending=%0d want=0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int n;
        int nv;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // Reset defaults
        repeat (3) @(negedge clock);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_busy", int'(busy), 0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_in_ready", int'(bus.in_ready), 1);

        // Identity pass-through with latency
        send(100, 1, 100, 1);
        send(-5, 1, -5, 1);
        send(4095, 1, 4095, 1);
        drain();

        // Four equal taps, step response
        for (int k = 0; k < 4; k++) wcoef(k, 2048);
        pulse_clr();
        for (int k = 1; k <= 6; k++) send(1000, 1, (k < 4 ? k : 4) * 1000, 0);
        drain();

        // Saturation at both rails, then round-half-up
        wcoef(2, 0);
        wcoef(3, 0);
        pulse_clr();
        send(4095, 1, 4095, 0);
        send(4095, 1, 4095, 0);
        send(4095, 1, 4095, 0);
        send(-4096, 1, -1, 0);
        send(-4096, 1, -4096, 0);
        send(-4096, 1, -4096, 0);
        drain();
        wcoef(0, 1024);
        wcoef(1, 0);
        pulse_clr();
        send(3, 1, 2, 0);
        send(-3, 1, -1, 0);
        send(1, 1, 1, 0);
        drain();

        // Decimation by 4, then a mid-frame ratio change
        wcoef(0, 2048);
        pulse_clr();
        dec_sel = DEC_4;
        for (int k = 1; k <= 16; k++) send(k, (k % 4) == 0, k, 0);
        drain();
        for (int k = 1; k <= 6; k++) send(k, k == 4, k, 0);
        dec_sel = DEC_1;
        send(7, 0, 0, 0);
        send(8, 1, 8, 0);
        send(9, 1, 9, 0);
        send(10, 1, 10, 0);
        drain();

        // Backpressure hold
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
        send(55, 1, 55, 0);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("bp_valid_seen", int'(bus.out_valid), 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("bp_hold_data", int'(bus.out_data), 55);
            chk("bp_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clock);
        #1 bus.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("bp_release_in_ready", int'(bus.in_ready), 1);
        chk("bp_release_valid", int'(bus.out_valid), 0);
        drain();

        // clr during MAC discards the frame and the history
        wcoef(1, 2048);
        pulse_clr();
        send(500, 0, 0, 0);
        repeat (5) @(negedge clock);
        pulse_clr();
        nv = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (bus.out_valid) nv++;
        end
        chk("clr_no_output", nv, 0);
        chk("clr_busy", int'(busy), 0);
        send(40, 1, 40, 0);
        drain();

        // Coefficient write while busy is dropped
        send(10, 1, 50, 0);
        @(negedge clock);
        chk("busy_in_mac", int'(busy), 1);
        wcoef(1, 0);
        drain();
        send(20, 1, 30, 0);
        drain();

        // Async reset mid-MAC
        wcoef(0, 1024);
        send(300, 0, 0, 0);
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(bus.out_valid), 0);
        chk("arst_busy", int'(busy), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        send(77, 1, 77, 0);
        send(5, 1, 5, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bc_fir_decim.md
Name: bc_fir_decim

Overview:
Parametrised, time-multiplexed binary FIR filter with runtime-selectable decimation, intended to replace the fixed per-rate FIR and input-control pairs in the multi-rate filter bank. Samples enter a delay line through a valid/ready handshake. Every R-th accepted sample triggers a sequential MAC pass of one tap per cycle. The rounded, saturated result is presented on a valid/ready output. Coefficients are register-loaded at runtime, and cascading instances builds the 1/2/4/8 decimation chains.

Parameters:
DATA_W, 13, signed two's-complement sample width for input and output.
COEF_W, 13, signed coefficient width.
COEF_FRAC, 11, fractional bits of a coefficient; 1.0 = 2048.
TAPS, 19, number of filter taps (order + 1).
ACC_W, DATA_W+COEF_W+$clog2(TAPS), derived localparam, accumulator width; not overridable.

Ports:
clock  in  1  single clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
clr  in  1  synchronous flush of delay line, decimation counter and FSM; coefficients are kept.
dec_sel  in  2  decimation ratio R: 0→1, 1→2, 2→4, 3→8.
in_data  in  DATA_W  input sample.
in_valid  in  1  input sample valid.
in_ready  out  1  block can accept a sample.
out_data  out  DATA_W  filtered, decimated sample.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts out_data.
coef_we  in  1  coefficient write strobe.
coef_addr  in  $clog2(TAPS)  tap index.
coef_data  in  COEF_W  coefficient value.
busy  out  1  high when FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - delay line all 0; decimation counter 0; FSM IDLE.
  - out_valid=0, out_data=0, in_ready=1 (once reset_n is high), busy=0.
  - coef[0]=1<<COEF_FRAC, all other taps 0, i.e. identity.
- Accept: in_valid&in_ready. The delay line shifts, d[0]=in_data, d[k]=d[k-1].
- Decimation counter increments per accept, compared against R-1. On the accept where count==R-1, the counter clears and the FSM enters MAC next cycle. R=1 triggers on every accept.
- dec_sel is latched into R_reg only in IDLE with counter==0. Changes mid-frame take effect from the next frame.
- FSM states:
  - IDLE: in_ready=1; trigger accept → MAC, acc cleared, idx=0.
  - MAC: in_ready=0; acc += d[idx]*coef[idx], full-precision signed; idx increments. After idx==TAPS-1 → OUT.
  - OUT: out_data = sat(round(acc)); out_valid=1; in_ready=0. When out_valid&out_ready → IDLE (in_ready=1 next cycle).
- Latency: trigger accept at cycle t → out_valid high at t+TAPS+1 at the earliest.
- Throughput: one output per max(R accepts, TAPS+2 cycles).
- Round/saturate:
  - acc + (1<<(COEF_FRAC-1)), then arithmetic shift right by COEF_FRAC.
  - Clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - No wrap is permitted at any stage.
- Backpressure: in OUT with out_ready=0, out_data and out_valid hold stable indefinitely and no input is accepted.
- Coefficient writes:
  - Take effect only when FSM is IDLE. Writes while busy=1 are dropped, with no partial update.
  - coef_addr ≥ TAPS is ignored.
  - A write in the same cycle as a trigger accept is applied, because the FSM is still IDLE.
- clr (priority over all other inputs):
  - Next cycle: delay line 0, counter 0, FSM IDLE, out_valid=0.
  - Any in-flight MAC or unconsumed output is discarded.
  - An accept coincident with clr is discarded.
- Async reset mid-MAC or mid-OUT: outputs go to reset values immediately; no stale result appears after release.

Decomposition:
- Package bc_fir_pkg holds:
  - fsm_e {IDLE, MAC, OUT};
  - dec_sel encoding constants and function dec_ratio(sel);
  - function sat_round(acc, frac, width).
- Sub-module bc_fir_mac: registered signed multiply-accumulate with clear, accumulate-enable and combinational round/saturate output. The top level owns the FSM, delay line, coefficient bank and handshakes.

Test Plan:
1. Reset defaults, dec_sel=0, inputs 100, -5, 4095 with out_ready=1 → outputs 100, -5, 4095 in order; each out_valid exactly TAPS+1=20 cycles after its accept.
2. Load coef[0..3]=2048, others 0; dec_sel=0; step input 1000 held for 6 samples → outputs 1000, 2000, 3000, 4000, 4000, 4000.
3. Saturation: coef[0]=coef[1]=2048; steady input 4095 → settles at 4095 (8190 clamped). Steady input -4096 → settles at -4096 (-8192 clamped).
4. Decimation: identity coefs, dec_sel=2, ramp 1..16 → exactly four outputs: 4, 8, 12, 16. Switching dec_sel to 0 mid-frame after input 6 takes effect only after output 8.
5. Backpressure/clr:
   - Hold out_ready=0 for 10 cycles in OUT → out_data stable, in_ready=0; release → one handshake, then in_ready=1.
   - clr during MAC → out_valid never rises for that frame; next output uses a zeroed history.
   - Coefficient write while busy=1 → coefficient is unchanged.
6. Assert reset_n low mid-MAC → out_valid=0, busy=0 immediately, coefficients back to identity; first post-reset input 77 yields output 77.
